// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing with pixel coordinates, syncs, blanking and frame pulse.
// Optional VGA_BLINK_EN adds a 64-frame blink square wave on port blink.
module vga_timing_gen #(
    parameter int   H_VIS  = 800,
    parameter int   H_FP   = 56,
    parameter int   H_SYNC = 120,
    parameter int   H_BP   = 64,
    parameter int   V_VIS  = 600,
    parameter int   V_FP   = 37,
    parameter int   V_SYNC = 6,
    parameter int   V_BP   = 23,
    parameter logic HS_POL = 1'b1,
    parameter logic VS_POL = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pix_ce,
    output logic [10:0] pixel_x,
    output logic [9:0]  pixel_y,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
`ifdef VGA_BLINK_EN
    output logic        frame_start,
    output logic        blink
`else
    output logic        frame_start
`endif
);
    localparam logic [10:0] H_LAST  = 11'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]  V_LAST  = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [10:0] HS_BEG  = 11'(H_VIS + H_FP);
    localparam logic [10:0] HS_END  = 11'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0]  VS_BEG  = 10'(V_VIS + V_FP);
    localparam logic [9:0]  VS_END  = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [10:0] H_VIS_W = 11'(H_VIS);
    localparam logic [9:0]  V_VIS_W = 10'(V_VIS);
    logic [10:0] h_cnt, h_nxt;
    logic [9:0]  v_cnt, v_nxt;
    logic        h_wrap, v_wrap;
    always_comb begin
        h_wrap = h_cnt == H_LAST;
        v_wrap = v_cnt == V_LAST;
        h_nxt  = h_wrap ? 11'd0 : h_cnt + 11'd1;
        v_nxt  = h_wrap ? (v_wrap ? 10'd0 : v_cnt + 10'd1) : v_cnt;
    end
    // Flags decode the next count so they line up with the coordinates they accompany.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            video_on    <= 1'b1;
            frame_start <= 1'b0;
        end else if (pix_ce) begin
            h_cnt       <= h_nxt;
            v_cnt       <= v_nxt;
            hsync       <= (h_nxt >= HS_BEG && h_nxt < HS_END) ? HS_POL : ~HS_POL;
            vsync       <= (v_nxt >= VS_BEG && v_nxt < VS_END) ? VS_POL : ~VS_POL;
            video_on    <= h_nxt < H_VIS_W && v_nxt < V_VIS_W;
            frame_start <= h_wrap && v_wrap;
        end else begin
            frame_start <= 1'b0;
        end
    end
    assign pixel_x = h_cnt;
    assign pixel_y = v_cnt;
`ifdef VGA_BLINK_EN
    logic [4:0] f_cnt;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f_cnt <= '0;
            blink <= 1'b0;
        end else if (pix_ce && h_wrap && v_wrap) begin
            f_cnt <= f_cnt + 5'd1;
            blink <= (&f_cnt) ? ~blink : blink;
        end
    end
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized pix_ce/reset stimulus scored against a linear-position raster model.
module tb_vga_timing_gen;
    localparam int HV = 16, HF = 3, HS = 5, HB = 6;
    localparam int VV = 8,  VF = 2, VS = 3, VB = 4;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int STEPS = 3900;
    typedef struct {
        logic [10:0] x;
        logic [9:0]  y;
        logic        hs, vs, vo, fs;
    } exp_t;
    logic        clk = 1'b0, reset_n, pix_ce;
    logic [10:0] pixel_x;
    logic [9:0]  pixel_y;
    logic        hsync, vsync, video_on, frame_start;
    exp_t        q[$];
    int          checks = 0, errors = 0;
    vga_timing_gen #(
        .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .pix_ce(pix_ce),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .hsync(hsync), .vsync(vsync),
        .video_on(video_on), .frame_start(frame_start)
    );
    always #5 clk = ~clk;
    // Position is a single index into the frame; coordinates and flags follow from the timing rules.
    function automatic exp_t model(int n, logic fs);
        exp_t e;
        int x = n % HT, y = n / HT;
        e.x  = 11'(x);
        e.y  = 10'(y);
        e.hs = x >= HV + HF && x < HV + HF + HS;
        e.vs = y >= VV + VF && y < VV + VF + VS;
        e.vo = x < HV && y < VV;
        e.fs = fs;
        return e;
    endfunction
    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask
    task automatic chk_all(exp_t e);
        chk("pixel_x", int'(pixel_x), int'(e.x));
        chk("pixel_y", int'(pixel_y), int'(e.y));
        chk("hsync", int'(hsync), int'(e.hs));
        chk("vsync", int'(vsync), int'(e.vs));
        chk("video_on", int'(video_on), int'(e.vo));
        chk("frame_start", int'(frame_start), int'(e.fs));
    endtask
    always @(negedge clk) begin
        if (q.size() != 0) chk_all(q.pop_front());
    end
    initial begin
        int   n = 0;
        logic fs = 1'b0;
        logic rst, ce;
        reset_n = 1'b0;
        pix_ce  = 1'b0;
        for (int s = 0; s < STEPS; s++) begin
            @(negedge clk);
            #1;
            rst = s < 3 || s == 1200 || s == 1201;
            ce  = s < 3000 ? (s < 1200 ? 1'b1 : 1'($urandom_range(0, 3) != 0)) : 1'(s % 3 == 0);
            if (rst) begin
                reset_n = 1'b0;
                n  = 0;
                fs = 1'b0;
                if (s == 1200) begin
                    #1;
                    chk_all(model(0, 1'b0));
                end
            end else begin
                reset_n = 1'b1;
                if (ce) begin
                    n  = (n + 1) % FT;
                    fs = n == 0;
                end else begin
                    fs = 1'b0;
                end
            end
            pix_ce = ce;
            q.push_back(model(n, fs));
        end
        repeat (3) @(negedge clk);
        #1;
        chk("scoreboard_drain", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates the 800×600 @ 72 Hz raster timing for the scoreboard video path. It produces the running pixel coordinates (`pixel_x`, `pixel_y`) that every glyph renderer (digits, colon, labels) consumes, plus `hsync`/`vsync` for the connector and a `video_on` blanking qualifier for the RGB mux. Counters advance on a pixel clock-enable, so the block runs from the system clock at any integer multiple of the pixel rate.

## Interface

Parameters:

- `H_VIS`, 800: visible pixels per line
- `H_FP`, 56: horizontal front porch, in pixels
- `H_SYNC`, 120: hsync width, in pixels
- `H_BP`, 64: horizontal back porch; line total `H_TOT` = 1040
- `V_VIS`, 600: visible lines
- `V_FP`, 37: vertical front porch, in lines
- `V_SYNC`, 6: vsync width, in lines
- `V_BP`, 23: vertical back porch; frame total `V_TOT` = 666
- `HS_POL`, 1'b1: active level of `hsync`
- `VS_POL`, 1'b1: active level of `vsync`

Ports:

- `clk` in 1: system clock; 50 MHz means one pixel per clock
- `reset_n` in 1: asynchronous, active-low reset
- `pix_ce` in 1: pixel advance enable; tie to 1 at 50 MHz
- `pixel_x` out 11: current column, 0…`H_TOT`-1
- `pixel_y` out 10: current line, 0…`V_TOT`-1
- `hsync` out 1: horizontal sync at `HS_POL`
- `vsync` out 1: vertical sync at `VS_POL`
- `video_on` out 1: high when `pixel_x < H_VIS` and `pixel_y < V_VIS`
- `frame_start` out 1: one-cycle pulse when position (0,0) is entered
- `blink` out 1: only with `VGA_BLINK_EN`; slow square wave for colon flashing

## Operation

- Two counters, `h_cnt` (11 b) and `v_cnt` (10 b), are driven directly onto `pixel_x` and `pixel_y`.
- On a cycle with `pix_ce` = 1:
  - `h_cnt` increments, wrapping `H_TOT`-1 → 0.
  - On that wrap, `v_cnt` increments, wrapping `V_TOT`-1 → 0.
  - There is no other way to wrap or clear the counters.
- On a cycle with `pix_ce` = 0, every output holds, including `frame_start`, which is forced to 0.
- `hsync` is active when `H_VIS+H_FP ≤ h_cnt < H_VIS+H_FP+H_SYNC` (856…975 with default parameters).
- `vsync` is active when `V_VIS+V_FP ≤ v_cnt < V_VIS+V_FP+V_SYNC` (637…642 with default parameters).
- `vsync` changes only on the same cycle that `h_cnt` wraps.
- `hsync`, `vsync`, `video_on` and `frame_start` are registered. They are decoded from the next counter value, so on every cycle they describe the `pixel_x`/`pixel_y` presented on that same cycle, with zero skew.
- Counters hold values up to 1039 and 665. Downstream blocks compare against these raw values; the block itself does no scaling.
- Reset values:
  - `pixel_x` = 0, `pixel_y` = 0
  - `hsync` = ~`HS_POL`, `vsync` = ~`VS_POL`
  - `video_on` = 1
  - `frame_start` = 0, so there is no pulse out of reset
  - `blink` = 0
- Reset asserted mid-frame returns all outputs to these values immediately, with no wait for a clock edge. Counting resumes from (0,0) on the first `pix_ce` after release.

## Timing

- Latency:
  - An output change follows the `clk` edge that samples `pix_ce` = 1.
  - There is no combinational path from `pix_ce` to any output.
- Line period: `H_TOT` pix_ce cycles. Frame period: `H_TOT`×`V_TOT` = 692 640 pix_ce cycles.
- `frame_start` is high for exactly the one cycle in which (`pixel_x`,`pixel_y`) becomes (0,0) after a wrap from (1039,665). If `pix_ce` is continuous, it is high for exactly one clk.
- Simultaneous horizontal and vertical wrap at (1039,665) in one cycle: next position is (0,0), `vsync` inactive, `video_on` = 1, `frame_start` = 1.
- Deasserting `reset_n` on the same edge as `pix_ce` = 1: that edge is ignored and the first advance happens on the next qualifying edge. `reset_n` release is synchronized externally.

## Configuration

- `VGA_BLINK_EN` defined:
  - Adds a 5-bit frame counter that increments on each `frame_start`.
  - `blink` toggles each time that counter wraps 31 → 0, giving a period of 64 frames (≈0.89 s at 72 Hz).
  - The counter resets to 0 and `blink` resets to 0.
- `VGA_BLINK_EN` undefined:
  - The frame counter is not built.
  - The `blink` port is absent.
  - All other behaviour is identical.

## Test plan

- Reset, then release with `pix_ce` = 1: `pixel_x`/`pixel_y` = 0/0, `hsync` = `vsync` = 0, `video_on` = 1, `frame_start` = 0. After 1040 clks: `pixel_x` = 0, `pixel_y` = 1.
- One line at `pix_ce` = 1:
  - `hsync` high for exactly 120 clks, rising while `pixel_x` = 856.
  - `video_on` falls when `pixel_x` = 800 and rises when `pixel_x` = 0.
- One frame:
  - `vsync` high for 6×1040 = 6240 clks, starting at (0,637).
  - `video_on` stays 0 for all of lines 600–665.
  - `frame_start` occurs exactly once, 692 640 clks after the previous one.
- `pix_ce` pattern 1,0,0,1 repeating: outputs hold during the 0 cycles, and the line period is 3120 clks. With `pix_ce` = 0 while at (1039,665), `frame_start` stays 0 until `pix_ce` returns.
- Assert `reset_n` = 0 asynchronously at (400,300): all outputs take their reset values before the next `clk` edge, and counting restarts from (0,0).
- With `VGA_BLINK_EN`: `blink` goes 0→1 after 32 `frame_start` pulses and back to 0 after 64. Without it, the build succeeds with no `blink` port.
